// File: rtl/apb_slave_pkg.sv
// ============================================================================
// Module   : apb_slave_pkg
// Function : Shared FSM state type, register offsets and field positions
// Revision : 1.0
// ============================================================================
`default_nettype none

package apb_slave_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic [11:0] c_off_ctrl     = 12'h000;
  localparam logic [11:0] c_off_status   = 12'h004;
  localparam logic [11:0] c_off_scratch0 = 12'h008;
  localparam logic [11:0] c_off_scratch1 = 12'h00C;
  localparam logic [11:0] c_off_wait     = 12'h010;
  localparam logic [11:0] c_off_count    = 12'h014;
  localparam logic [11:0] c_off_id       = 12'h018;
  localparam logic [11:0] c_off_limit    = 12'h01C;

  localparam int c_ctrl_cnt_en_bit  = 0;
  localparam int c_ctrl_ovf_clr_bit = 1;
  localparam int c_status_ovf_bit   = 0;
  localparam int c_wait_width       = 4;

endpackage

`default_nettype wire

// File: rtl/apb_reg_slave.sv
// ============================================================================
// Module   : apb_reg_slave
// Function : APB register slave with programmable wait states and free counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_reg_slave
  import apb_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'hA9B0_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o
);

  apb_state_e              r_state;
  logic [11:0]             r_addr;
  logic                    r_write;
  logic [c_wait_width-1:0] r_wait_cnt;

  logic                    r_cnt_en;
  logic                    r_ovf;
  logic [DATA_WIDTH-1:0]   r_scratch0;
  logic [DATA_WIDTH-1:0]   r_scratch1;
  logic [c_wait_width-1:0] r_wait;
  logic [DATA_WIDTH-1:0]   r_count;

  logic                    w_pready;
  logic                    w_err;
  logic                    w_wr_en;
  logic                    w_ovf_clr;
  logic                    w_wrap;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_unused_paddr;

  assign w_unused_paddr = ^paddr_i[ADDR_WIDTH-1:12];

  // Decode works on the address latched in setup, not the live bus
  assign w_pready = (r_state == ACCESS) && (r_wait_cnt == '0) && psel_i && penable_i;
  assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr >= c_off_limit) ||
                    (r_write && ((r_addr == c_off_status) || (r_addr == c_off_count) ||
                                 (r_addr == c_off_id)));
  assign w_wr_en  = w_pready && r_write && !w_err;

  assign w_ovf_clr = w_wr_en && (r_addr == c_off_ctrl) && pwdata_i[c_ctrl_ovf_clr_bit];
  assign w_wrap    = r_cnt_en && (r_count == '1);

  assign pready_o  = w_pready;
  assign pslverr_o = w_pready && w_err;
  assign prdata_o  = (w_pready && !r_write && !w_err) ? w_rdata : '0;

  always_comb begin
    w_rdata = '0;
    unique case (r_addr)
      c_off_ctrl:     w_rdata[c_ctrl_cnt_en_bit] = r_cnt_en;
      c_off_status:   w_rdata[c_status_ovf_bit]  = r_ovf;
      c_off_scratch0: w_rdata = r_scratch0;
      c_off_scratch1: w_rdata = r_scratch1;
      c_off_wait:     w_rdata[c_wait_width-1:0] = r_wait;
      c_off_count:    w_rdata = r_count;
      c_off_id:       w_rdata = DATA_WIDTH'(ID_VALUE);
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (psel_i && !penable_i) begin
            r_addr     <= paddr_i[11:0];
            r_write    <= pwrite_i;
            r_wait_cnt <= r_wait;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          // A master dropping psel/penable early abandons the transfer
          if (!(psel_i && penable_i)) begin
            r_wait_cnt <= '0;
            r_state    <= IDLE;
          end else if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_en   <= 1'b0;
      r_scratch0 <= '0;
      r_scratch1 <= '0;
      r_wait     <= '0;
    end else if (w_wr_en) begin
      case (r_addr)
        c_off_ctrl:     r_cnt_en   <= pwdata_i[c_ctrl_cnt_en_bit];
        c_off_scratch0: r_scratch0 <= pwdata_i;
        c_off_scratch1: r_scratch1 <= pwdata_i;
        c_off_wait:     r_wait     <= pwdata_i[c_wait_width-1:0];
        default: ;
      endcase
    end
  end

  // Counter sees the CTRL value from before any same-cycle write; wrap beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_cnt_en) begin
        r_count <= r_count + DATA_WIDTH'(1);
      end
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
// ============================================================================
// Module   : tb_apb_reg_slave
// Function : Directed scoreboard bench for the APB register slave
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_reg_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  apb_reg_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .paddr_i   (paddr),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Push the expectation, run one full APB transfer, pop and compare on pready
  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic err, input int lat);
    exp_t e;
    int   waited;
    sb.push_back('{tag, rdata, err, lat});
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!pready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    e = sb.pop_front();
    if (!pready) begin
      chk({e.tag, "_timeout"}, 32'(pready), 32'd1);
    end else begin
      chk({e.tag, "_rdata"}, prdata, e.rdata);
      chk({e.tag, "_err"}, 32'(pslverr), 32'(e.err));
      chk({e.tag, "_lat"}, 32'(waited), 32'(e.lat));
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    rst_n = 1'b1;

    // Zero-wait register access and ID with three wait states
    xfer("wr_scr0", 32'h08, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    xfer("rd_scr0", 32'h08, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    xfer("wr_scr1", 32'h0C, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
    xfer("wr_wait3", 32'h10, 1'b1, 32'h3, 32'h0, 1'b0, 0);
    xfer("rd_id", 32'h18, 1'b0, 32'h0, 32'hA9B0_0001, 1'b0, 3);
    xfer("rd_wait", 32'h10, 1'b0, 32'h0, 32'h3, 1'b0, 3);
    xfer("wr_wait0", 32'h10, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0, 3);
    xfer("rd_wait0", 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 0);

    // Error responses leave state untouched
    xfer("wr_count", 32'h14, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 0);
    xfer("wr_oob", 32'h20, 1'b1, 32'h1, 32'h0, 1'b1, 0);
    xfer("rd_unal", 32'h09, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    xfer("wr_id", 32'h18, 1'b1, 32'h5, 32'h0, 1'b1, 0);
    xfer("rd_count0", 32'h14, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    xfer("rd_scr0_b", 32'h08, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    xfer("rd_ctrl_ro", 32'h00, 1'b0, 32'h0, 32'h0, 1'b0, 0);

    // Counter wrap sets ovf; ovf_clr clears it and leaves cnt_en set
    xfer("wr_ctrl1", 32'h00, 1'b1, 32'h1, 32'h0, 1'b0, 0);
    xfer("rd_stat0", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    @(negedge clk);
    force dut.r_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.r_count;
    repeat (3) @(posedge clk);
    xfer("rd_stat1", 32'h04, 1'b0, 32'h0, 32'h1, 1'b0, 0);
    xfer("wr_ctrl3", 32'h00, 1'b1, 32'h3, 32'h0, 1'b0, 0);
    xfer("rd_stat_clr", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    xfer("rd_ctrl1", 32'h00, 1'b0, 32'h0, 32'h1, 1'b0, 0);
    xfer("wr_ctrl0", 32'h00, 1'b1, 32'h0, 32'h0, 1'b0, 0);

    // Abort a waited write by dropping penable, then a normal transfer
    xfer("wr_wait5", 32'h10, 1'b1, 32'h5, 32'h0, 1'b0, 0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_wait1", 32'(pready), 32'd0);
    @(negedge clk);
    chk("abort_wait2", 32'(pready), 32'd0);
    penable = 1'b0; psel = 1'b0;
    @(negedge clk);
    chk("abort_idle_rdy", 32'(pready), 32'd0);
    xfer("rd_scr1_keep", 32'h0C, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 5);
    xfer("wr_wait0_b", 32'h10, 1'b1, 32'h0, 32'h0, 1'b0, 5);

    // Reset in the access phase of a ready write
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    chk("pre_rst_rdy", 32'(pready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pready", 32'(pready), 32'd0);
    chk("mid_rst_pslverr", 32'(pslverr), 32'd0);
    chk("mid_rst_prdata", prdata, 32'd0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer("rd_scr0_rst", 32'h08, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    xfer("rd_scr1_rst", 32'h0C, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    xfer("rd_count_rst", 32'h14, 1'b0, 32'h0, 32'h0, 1'b0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: APB address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32: APB data width.
REQ-004 The block SHALL have parameter ID_VALUE, default 32'hA9B0_0001: value returned by the ID register.
REQ-005 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-006 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 The block SHALL have port paddr_i, input, ADDR_WIDTH: APB address; only bits [11:0] are decoded.
REQ-008 The block SHALL have port psel_i, input, 1: slave select, driven by one bit of the upstream bridge psel.
REQ-009 The block SHALL have ports penable_i, pwrite_i and pwdata_i, inputs, 1/1/DATA_WIDTH: APB access-phase flag, direction, write data.
REQ-010 The block SHALL have ports prdata_o, pready_o and pslverr_o, outputs, DATA_WIDTH/1/1: read data, ready, error.

Function
REQ-011 Register map (offset: name, access): 0x00 CTRL RW [bit0 cnt_en, bit1 ovf_clr self-clearing, reads 0]; 0x04 STATUS RO [bit0 ovf sticky]; 0x08 SCRATCH0 RW; 0x0C SCRATCH1 RW; 0x10 WAIT RW [3:0]; 0x14 COUNT RO; 0x18 ID RO. Unimplemented bits SHALL read 0.
REQ-012 FSM states SHALL be IDLE and ACCESS.
REQ-013 IDLE: psel_i=1 and penable_i=0 (setup) SHALL latch paddr_i[11:0] and pwrite_i, load wait_cnt with WAIT[3:0], and move to ACCESS.
REQ-014 ACCESS: while wait_cnt!=0, pready_o SHALL be 0 and wait_cnt SHALL decrement by 1 each cycle.
REQ-015 ACCESS: when wait_cnt==0 and psel_i=penable_i=1, pready_o SHALL be 1 combinationally and the FSM SHALL return to IDLE on that edge; latency = WAIT+1 access cycles.
REQ-016 A write SHALL commit on the clock edge where pready_o=1, and only with no error.
REQ-017 prdata_o SHALL carry register data only while pready_o=1 and pwrite=0; otherwise it SHALL be 0.
REQ-018 pslverr_o SHALL be 1 only with pready_o=1, for any of these cases: offset ≥0x1C, paddr[1:0]!=0, or a write to STATUS, COUNT or ID; such a transfer SHALL have no side effects, and an errored read SHALL return 0.
REQ-019 psel_i or penable_i falling in ACCESS before completion SHALL return the FSM to IDLE, with no commit and pready_o=0.
REQ-020 COUNT SHALL increment by 1 per cycle when cnt_en=1 (using the pre-write CTRL value), wrap from 0xFFFF_FFFF to 0, and set ovf on the wrap.
REQ-021 Writing CTRL with bit1=1 SHALL clear ovf; a wrap in the same cycle SHALL win, leaving ovf at 1.
REQ-022 A write to WAIT SHALL affect only subsequent transfers.

Reset
REQ-023 rst_n=0 SHALL asynchronously force FSM=IDLE, wait_cnt=0, CTRL=0, ovf=0, SCRATCH0/1=0, WAIT=0, COUNT=0.
REQ-024 During reset, prdata_o=0, pready_o=0 and pslverr_o=0; reset mid-transfer SHALL abort it without commit.

Structure
REQ-025 A shared package apb_slave_pkg SHALL hold the state enum, the register offset localparams and the field bit positions.
REQ-026 The block SHALL be a single module with no sub-module; the register file, decode and FSM are inline, with a target of 120-400 RTL lines.

Verification
REQ-027 With reset and WAIT=0: write 0xDEADBEEF to 0x08, then read 0x08 -> pready_o=1 in the first access cycle, prdata_o=0xDEADBEEF, pslverr_o=0.
REQ-028 Write WAIT=3, then read 0x18 -> pready_o low for 3 access cycles, high on the 4th, prdata_o=0xA9B00001.
REQ-029 Write to 0x14, write to 0x20, and read 0x09 -> pslverr_o=1 with pready_o for each; COUNT unchanged; read data 0.
REQ-030 Set CTRL=1 with COUNT forced near 0xFFFF_FFFE -> COUNT wraps to 0, STATUS reads 1; write CTRL=3 -> STATUS reads 0 and cnt_en stays 1.
REQ-031 Drop penable_i mid-wait (WAIT=5) on a write to 0x0C -> FSM returns to IDLE, SCRATCH1 unchanged, and the next transfer completes normally.
REQ-032 Assert rst_n=0 in ACCESS during a write to 0x08 -> outputs 0 immediately, and SCRATCH0 reads 0 after release.
